// File: rtl/cordic_shift_pipe_pkg.sv
// rtl/cordic_shift_pipe_pkg.sv - shared constants and beat sideband layout for the CORDIC shift pipeline
//
// Purpose: default datapath widths and the bit layout of the per-beat sideband
//          {tag, round, arith, shift} that travels alongside the data through
//          every pipeline stage.
package cordic_shift_pipe_pkg;

    localparam int REG_SIZE  = 15;
    localparam int WIDTH_DEF = REG_SIZE + 1;
    localparam int SHW_DEF   = 4;
    localparam int TAGW_DEF  = 4;

    // Sideband layout, LSB first: shift[SHW-1:0], arith, round, tag[TAGW-1:0].
    localparam int SB_SHIFT_LSB = 0;

    function automatic int sb_arith_bit(input int shw);
        return shw;
    endfunction

    function automatic int sb_round_bit(input int shw);
        return shw + 1;
    endfunction

    function automatic int sb_tag_lsb(input int shw);
        return shw + 2;
    endfunction

    function automatic int sb_width(input int shw, input int tagw);
        return shw + 2 + tagw;
    endfunction

endpackage

// File: rtl/cordic_shift_stage.sv
// rtl/cordic_shift_stage.sv - one registered radix-2 right-shift stage with guard/sticky tracking
//
// Purpose: conditionally shifts the operand right by DIST (sign or zero fill),
//          captures the last bit shifted out as the new guard bit and folds the
//          old guard plus all lower shifted-out bits into sticky. Registers the
//          result when en is high; holds otherwise.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   en                     pipeline advance
//   in_valid / out_valid   beat valid
//   in_sel                 this stage's shift-amount bit
//   in_arith               1 = sign fill, 0 = zero fill
//   in_data / out_data     operand
//   in_guard / out_guard   most recent bit shifted out
//   in_sticky / out_sticky OR of bits shifted out below the guard
//   in_sb / out_sb         sideband carried unchanged
module cordic_shift_stage
    import cordic_shift_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIST  = 1,
    parameter int SBW   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic             in_arith,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_guard,
    input  logic             in_sticky,
    input  logic [SBW-1:0]   in_sb,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_guard,
    output logic             out_sticky,
    output logic [SBW-1:0]   out_sb
);

    // Every shifted-out bit except the topmost (which becomes the guard).
    localparam logic [DIST-1:0] LO_MASK = {DIST{1'b1}} >> 1;

    logic                  fill;
    logic [WIDTH+DIST-1:0] ext;
    logic [DIST-1:0]       shifted_out;

    logic             valid_d,  valid_q;
    logic [WIDTH-1:0] data_d,   data_q;
    logic             guard_d,  guard_q;
    logic             sticky_d, sticky_q;
    logic [SBW-1:0]   sb_d,     sb_q;

    always_comb begin
        fill        = in_arith & in_data[WIDTH-1];
        // Extending by DIST fill bits also covers DIST > WIDTH: the
        // shifted-out window then contains fill bits as well as data.
        ext         = {{DIST{fill}}, in_data};
        shifted_out = ext[DIST-1:0];

        valid_d  = in_valid;
        sb_d     = in_sb;
        data_d   = in_data;
        guard_d  = in_guard;
        sticky_d = in_sticky;
        if (in_sel) begin
            data_d   = ext[WIDTH+DIST-1:DIST];
            guard_d  = shifted_out[DIST-1];
            sticky_d = in_sticky | in_guard | (|(shifted_out & LO_MASK));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            sb_q     <= '0;
        end else if (en) begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            sb_q     <= sb_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_guard  = guard_q;
    assign out_sticky = sticky_q;
    assign out_sb     = sb_q;

endmodule

// File: rtl/cordic_shift_pipe.sv
// rtl/cordic_shift_pipe.sv - pipelined right barrel shifter with rounding and sticky for the CORDIC datapath
//
// Purpose: SHW registered radix-2 shift stages followed by a registered
//          rounding/output stage. Latency SHW+1, one beat per clock, single
//          global stall driven by the output handshake.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake (in_ready = advance)
//   in_data, in_shift          operand and right-shift amount
//   in_arith, in_round         sign fill / round-half-up select
//   in_tag                     sideband returned with the result
//   out_valid/out_ready        output handshake
//   out_data, out_sticky       result and OR of bits below the guard
//   out_tag                    tag of the output beat
module cordic_shift_pipe
    import cordic_shift_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF,
    parameter int TAGW  = TAGW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic             in_arith,
    input  logic             in_round,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky,
    output logic [TAGW-1:0]  out_tag
);

    localparam int SBW      = sb_width(SHW, TAGW);
    localparam int SB_ARITH = sb_arith_bit(SHW);
    localparam int SB_ROUND = sb_round_bit(SHW);
    localparam int SB_TAG   = sb_tag_lsb(SHW);

    logic adv;

    logic [SHW:0]            st_valid;
    logic [SHW:0]            st_guard;
    logic [SHW:0]            st_sticky;
    logic [SHW:0][WIDTH-1:0] st_data;
    logic [SHW:0][SBW-1:0]   st_sb;

    logic             out_valid_d,  out_valid_q;
    logic [WIDTH-1:0] out_data_d,   out_data_q;
    logic             out_sticky_d, out_sticky_q;
    logic [TAGW-1:0]  out_tag_d,    out_tag_q;

    logic last_round;
    logic unused_sb;

    // One enable for the whole pipe: bubbles are carried, never collapsed.
    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;

    assign st_valid[0]  = in_valid;
    assign st_guard[0]  = 1'b0;
    assign st_sticky[0] = 1'b0;
    assign st_data[0]   = in_data;
    assign st_sb[0]     = {in_tag, in_round, in_arith, in_shift};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        cordic_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k),
            .SBW   (SBW)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (adv),
            .in_valid   (st_valid[k]),
            .in_sel     (st_sb[k][SB_SHIFT_LSB + k]),
            .in_arith   (st_sb[k][SB_ARITH]),
            .in_data    (st_data[k]),
            .in_guard   (st_guard[k]),
            .in_sticky  (st_sticky[k]),
            .in_sb      (st_sb[k]),
            .out_valid  (st_valid[k+1]),
            .out_data   (st_data[k+1]),
            .out_guard  (st_guard[k+1]),
            .out_sticky (st_sticky[k+1]),
            .out_sb     (st_sb[k+1])
        );
    end

    assign last_round = st_sb[SHW][SB_ROUND];
    // Shift amount and fill mode are fully consumed by the shift stages.
    assign unused_sb  = ^st_sb[SHW][SB_ROUND-1:0];

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sticky_d = out_sticky_q;
        out_tag_d    = out_tag_q;
        if (adv) begin
            out_valid_d  = st_valid[SHW];
            // Round half up; the sum wraps at WIDTH bits.
            out_data_d   = st_data[SHW] + WIDTH'(last_round & st_guard[SHW]);
            out_sticky_d = st_sticky[SHW];
            out_tag_d    = st_sb[SHW][SB_TAG +: TAGW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sticky_q <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sticky_q <= out_sticky_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sticky = out_sticky_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_cordic_shift_pipe.sv
// tb/tb_cordic_shift_pipe.sv - directed self-checking bench for cordic_shift_pipe
module tb_cordic_shift_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shift;
    logic        in_arith;
    logic        in_round;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sticky;
    logic [3:0]  out_tag;

    int errors = 0;
    int checks = 0;

    cordic_shift_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shift   (in_shift),
        .in_arith   (in_arith),
        .in_round   (in_round),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference: place operand above a 16-bit fraction, shift, read result/guard/sticky.
    function automatic logic [16:0] model(input logic [15:0] d, input int sh,
                                          input logic ar, input logic rd);
        logic [31:0] w;
        w = {d, 16'h0000};
        if (ar) w = 32'($signed(w) >>> sh);
        else    w = w >> sh;
        return {|w[14:0], w[31:16] + {15'b0, rd & w[15]}};
    endfunction

    // Single isolated beat; inputs change 1 time unit after a rising edge.
    task automatic single(input string name, input logic [15:0] d, input logic [3:0] sh,
                          input logic ar, input logic rd, input logic [3:0] tg,
                          input logic [15:0] exp_d, input logic exp_s);
        int lat;
        in_valid  = 1'b1;
        in_data   = d;
        in_shift  = sh;
        in_arith  = ar;
        in_round  = rd;
        in_tag    = tg;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, 5);
        chk({name, "_data"}, out_data, exp_d);
        chk({name, "_sticky"}, out_sticky, exp_s);
        chk({name, "_tag"}, out_tag, tg);
        @(posedge clk); #1;
        chk({name, "_drain"}, out_valid, 0);
    endtask

    // Streams n beats back to back with an optional output stall window,
    // scoreboarding every output and checking hold-while-stalled.
    task automatic stream(input string name, input int n, input int stall_at, input int stall_len,
                          input logic ar, input logic rd, input logic [15:0] base,
                          input int exp_first, input int exp_last);
        logic [20:0] exp_q[$];
        logic [20:0] prev;
        logic [20:0] front;
        logic        prev_stall;
        int sent, got, cyc, first_cyc, last_cyc;
        logic [15:0] d;
        sent = 0; got = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
        prev = '0; prev_stall = 1'b0;
        while (got < n && cyc < 200) begin
            d         = base + 16'(sent) * 16'h0F1D;
            in_valid  = (sent < n);
            in_data   = d;
            in_shift  = 4'(sent);
            in_tag    = 4'(sent);
            in_arith  = ar;
            in_round  = rd;
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (prev_stall) begin
                chk({name, "_hold_valid"}, out_valid, 1);
                chk({name, "_hold_beat"}, {out_tag, out_sticky, out_data}, prev);
            end
            if (out_valid && !out_ready) chk({name, "_in_ready_low"}, in_ready, 0);
            prev_stall = out_valid && !out_ready;
            prev = {out_tag, out_sticky, out_data};
            if (out_valid && out_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk({name, "_spurious_beat"}, 1, 0);
                end else begin
                    front = exp_q.pop_front();
                    chk({name, "_beat"}, {out_tag, out_sticky, out_data}, front);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({4'(sent), model(d, sent, ar, rd)});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({name, "_count"}, got, n);
        chk({name, "_first_cycle"}, first_cyc, exp_first);
        chk({name, "_last_cycle"}, last_cyc, exp_last);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_arith  = 1'b0;
        in_round  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_sticky", out_sticky, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        single("logical_f000_s4",   16'hF000, 4'd4,  1'b0, 1'b0, 4'd1, 16'h0F00, 1'b0);
        single("arith_rnd_s1",      16'h8003, 4'd1,  1'b1, 1'b1, 4'd2, 16'hC002, 1'b0);
        single("arith_rnd_s2",      16'h8003, 4'd2,  1'b1, 1'b1, 4'd3, 16'hE001, 1'b1);
        single("arith_trunc_s2",    16'h8003, 4'd2,  1'b1, 1'b0, 4'd4, 16'hE000, 1'b1);
        single("logical_8003_s1",   16'h8003, 4'd1,  1'b0, 1'b0, 4'd5, 16'h4001, 1'b0);
        single("sticky_trunc",      16'h0007, 4'd3,  1'b0, 1'b0, 4'd6, 16'h0000, 1'b1);
        single("sticky_round",      16'h0007, 4'd3,  1'b0, 1'b1, 4'd7, 16'h0001, 1'b1);
        single("shift0_passthru",   16'h8003, 4'd0,  1'b1, 1'b1, 4'd8, 16'h8003, 1'b0);
        single("arith_max_shift",   16'h8000, 4'd15, 1'b1, 1'b0, 4'd9, 16'hFFFF, 1'b0);
        single("logical_max_shift", 16'h8000, 4'd15, 1'b0, 1'b0, 4'd10, 16'h0001, 1'b0);
        single("round_wrap",        16'hFFFF, 4'd15, 1'b1, 1'b1, 4'd11, 16'h0000, 1'b1);
        single("arith_pos_same",    16'h7ABC, 4'd5,  1'b1, 1'b0, 4'd12, 16'h03D5, 1'b1);

        stream("b2b16", 16, 1000, 0, 1'b0, 1'b0, 16'hA5C3, 5, 20);
        stream("b2b16_ar", 16, 1000, 0, 1'b1, 1'b1, 16'hC3A5, 5, 20);
        stream("stall8", 8, 6, 3, 1'b1, 1'b0, 16'h9137, 5, 15);

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234 + 16'(i);
            in_shift = 4'd1;
            in_tag   = 4'(i + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midreset_no_stale", out_valid, 0);
        end
        single("after_reset", 16'h0F00, 4'd8, 1'b0, 1'b0, 4'd13, 16'h000F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
